// File: rtl/io_ctc16.sv
// Two-channel memory-mapped timer/counter on the CPU IO bus.
// Each channel counts clocks or synchronised external edges and pulses cout at terminal count.
module io_ctc16 #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctcread,
    input  logic             ctcwrite,
    input  logic [2:0]       address,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    input  logic             pulse0,
    input  logic             pulse1,
    output logic             cout0,
    output logic             cout1
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0][1:0]             mode_r;
    logic [1:0][WIDTH-1:0]       init_r;
    logic [1:0][WIDTH-1:0]       cnt_r;
    logic [1:0][SYNC_STAGES-1:0] sync_r;
    logic [1:0]                  running_r;
    logic [1:0]                  done_r;
    logic [1:0]                  cout_r;
    logic [1:0]                  prev_r;
    logic [1:0]                  edge_r;

    logic [1:0] pulse_s;
    logic [1:0] wr_mode_s;
    logic [1:0] wr_init_s;
    logic [1:0] rd_stat_s;
    logic [1:0] tick_s;
    logic [1:0] tc_s;

    // Per-channel strobe decode and tick / terminal-count qualification.
    always_comb begin
        pulse_s   = {pulse1, pulse0};
        wr_mode_s = 2'b00;
        wr_init_s = 2'b00;
        rd_stat_s = 2'b00;
        tick_s    = 2'b00;
        tc_s      = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            wr_mode_s[ch] = ctcwrite && !address[0] && !address[2] && (address[1] == ch[0]);
            wr_init_s[ch] = ctcwrite && !address[0] &&  address[2] && (address[1] == ch[0]);
            rd_stat_s[ch] = ctcread  && !address[0] && !address[2] && (address[1] == ch[0]);
            tick_s[ch]    = running_r[ch] && (mode_r[ch][0] ? edge_r[ch] : 1'b1);
            tc_s[ch]      = tick_s[ch] && (cnt_r[ch] == CNT_ONE);
        end
    end

    // Read mux: status or live count of the addressed channel, zero otherwise.
    always_comb begin
        rdata = CNT_ZERO;
        if (ctcread && !address[0]) begin
            if (address[2]) begin
                rdata = cnt_r[address[1]];
            end else begin
                rdata = {running_r[address[1]], {(WIDTH-4){1'b0}},
                         done_r[address[1]], mode_r[address[1]]};
            end
        end else begin
            rdata = CNT_ZERO;
        end
    end

    // Channel state: writes take priority over terminal count, which beats read-to-clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_r    <= '{default: 2'b00};
            init_r    <= '{default: CNT_ZERO};
            cnt_r     <= '{default: CNT_ZERO};
            sync_r    <= '{default: {SYNC_STAGES{1'b0}}};
            running_r <= 2'b00;
            done_r    <= 2'b00;
            cout_r    <= 2'b00;
            prev_r    <= 2'b00;
            edge_r    <= 2'b00;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                // Edge detection runs even while stopped; tick_s gates the result.
                sync_r[ch] <= {sync_r[ch][SYNC_STAGES-2:0], pulse_s[ch]};
                prev_r[ch] <= sync_r[ch][SYNC_STAGES-1];
                edge_r[ch] <= sync_r[ch][SYNC_STAGES-1] && !prev_r[ch];
                cout_r[ch] <= 1'b0;
                if (wr_mode_s[ch]) begin
                    mode_r[ch]    <= wdata[1:0];
                    running_r[ch] <= 1'b0;
                    done_r[ch]    <= 1'b0;
                end else if (wr_init_s[ch]) begin
                    if (wdata != CNT_ZERO) begin
                        init_r[ch]    <= wdata;
                        cnt_r[ch]     <= wdata;
                        running_r[ch] <= 1'b1;
                        done_r[ch]    <= 1'b0;
                    end else begin
                        init_r[ch]    <= CNT_ZERO;
                        cnt_r[ch]     <= CNT_ZERO;
                        running_r[ch] <= 1'b0;
                    end
                end else if (tc_s[ch]) begin
                    cout_r[ch] <= 1'b1;
                    done_r[ch] <= 1'b1;
                    if (mode_r[ch][1]) begin
                        cnt_r[ch] <= init_r[ch];
                    end else begin
                        cnt_r[ch]     <= CNT_ZERO;
                        running_r[ch] <= 1'b0;
                    end
                end else begin
                    if (tick_s[ch] && (cnt_r[ch] > CNT_ONE)) begin
                        cnt_r[ch] <= cnt_r[ch] - CNT_ONE;
                    end
                    if (rd_stat_s[ch]) begin
                        done_r[ch] <= 1'b0;
                    end
                end
            end
        end
    end

    assign cout0 = cout_r[0];
    assign cout1 = cout_r[1];

endmodule
